// File: rtl/seq_pattern_detector.sv
// Streaming detector for a run-time programmable symbol sequence.
// Pulses match one cycle after the completing symbol and keeps a saturating hit count.
module seq_pattern_detector #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
  input  logic                     cfg_overlap,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_data,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count,
  output logic [LEN_W-1:0]         fill
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [MAX_LEN-1:0][SYM_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]              fill_q, fill_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          match_q, match_d;

  logic [SYM_W-1:0] pat_sym [MAX_LEN];
  logic [SYM_W-1:0] win     [MAX_LEN+1];
  logic [IDX_W-1:0] pat_idx;
  logic [LEN_W:0]   fill_p1;
  logic             len_ok, fill_ok, pat_ok, hit;

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      pat_sym[i] = cfg_pattern[i*SYM_W +: SYM_W];
    end
    // win[0] is the incoming symbol, older history follows
    win[0] = in_data;
    for (int k = 1; k <= MAX_LEN; k++) begin
      win[k] = hist_q[k-1];
    end
  end

  always_comb begin
    len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    fill_p1 = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    fill_ok = fill_p1 >= {1'b0, cfg_len};
    pat_ok  = 1'b1;
    pat_idx = '0;
    // Newest symbol must equal the last pattern symbol, and so on backwards
    for (int j = 0; j <= MAX_LEN; j++) begin
      if (len_ok && (j < int'(cfg_len))) begin
        pat_idx = IDX_W'(int'(cfg_len) - 1 - j);
        if (win[j] != pat_sym[pat_idx]) begin
          pat_ok = 1'b0;
        end
      end
    end
    hit = in_valid && len_ok && fill_ok && pat_ok;
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      for (int k = MAX_LEN - 1; k >= 1; k--) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0] = in_data;
      if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
      if (hit) begin
        match_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Non-overlapping mode: shifted symbols stay but no longer count as history
        if (!cfg_overlap) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector with hand-computed expectations.
module tb_seq_pattern_detector;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic [3:0]  cfg_len;
  logic [23:0] cfg_pattern;
  logic        cfg_overlap;
  logic        in_valid;
  logic [2:0]  in_data;
  logic        match;
  logic [7:0]  match_count;
  logic [3:0]  fill;

  int checks = 0;
  int failures = 0;

  seq_pattern_detector #(.SYM_W(3), .MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .cfg_len(cfg_len),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .in_valid(in_valid),
    .in_data(in_data),
    .match(match),
    .match_count(match_count),
    .fill(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  // pattern 1,5,6,0,6,6,3 with symbol 0 in the low bits
  task automatic set_pat7();
    cfg_pattern = {3'd0, 3'd3, 3'd6, 3'd6, 3'd0, 3'd6, 3'd5, 3'd1};
  endtask

  task automatic send(input logic [2:0] sym);
    in_valid = 1'b1;
    in_data  = sym;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
    checks++;
    if (match_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", match_count); end
    checks++;
    if (fill !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    reset_n = 1'b1;
    idle();
    checks++;
    if (match !== 1'b0 || fill !== 4'd0) begin
      failures++; $display("FAIL reset_release match=%b fill=%0d exp 0/0", match, fill);
    end
  endtask

  task automatic test_basic();
    int s [9] = '{4, 1, 5, 6, 0, 6, 6, 3, 5};
    cfg_len = 4'd7; set_pat7(); cfg_overlap = 1'b1;
    do_clear();
    for (int i = 0; i < 9; i++) begin
      send(3'(s[i]));
      checks++;
      if (match !== 1'(i == 7)) begin
        failures++; $display("FAIL basic_match i=%0d got=%b exp=%b", i, match, (i == 7));
      end
    end
    checks++;
    if (match_count !== 8'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", match_count); end
    checks++;
    if (fill !== 4'd8) begin failures++; $display("FAIL basic_fill got=%0d exp=8", fill); end
  endtask

  task automatic test_overlap();
    cfg_len = 4'd3; cfg_pattern = {15'd0, 3'd2, 3'd2, 3'd2};
    cfg_overlap = 1'b1;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      send(3'd2);
      checks++;
      if (match !== 1'(i >= 2)) begin
        failures++; $display("FAIL overlap_match i=%0d got=%b exp=%b", i, match, (i >= 2));
      end
    end
    checks++;
    if (match_count !== 8'd3) begin failures++; $display("FAIL overlap_count got=%0d exp=3", match_count); end
    cfg_overlap = 1'b0;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      send(3'd2);
      checks++;
      if (match !== 1'(i == 2)) begin
        failures++; $display("FAIL nonoverlap_match i=%0d got=%b exp=%b", i, match, (i == 2));
      end
    end
    checks++;
    if (match_count !== 8'd1) begin failures++; $display("FAIL nonoverlap_count got=%0d exp=1", match_count); end
    checks++;
    if (fill !== 4'd2) begin failures++; $display("FAIL nonoverlap_fill got=%0d exp=2", fill); end
  endtask

  task automatic test_idle_gaps();
    int p [7] = '{1, 5, 6, 0, 6, 6, 3};
    int n;
    cfg_len = 4'd7; set_pat7(); cfg_overlap = 1'b1;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        idle();
        checks++;
        if (match !== 1'b0) begin failures++; $display("FAIL gap_idle i=%0d got=%b exp=0", i, match); end
      end
      send(3'(p[i]));
      checks++;
      if (match !== 1'(i == 6)) begin
        failures++; $display("FAIL gap_match i=%0d got=%b exp=%b", i, match, (i == 6));
      end
    end
    idle();
    checks++;
    if (match !== 1'b0) begin failures++; $display("FAIL gap_pulse_width got=%b exp=0", match); end
    checks++;
    if (match_count !== 8'd1) begin failures++; $display("FAIL gap_count got=%0d exp=1", match_count); end
    checks++;
    if (fill !== 4'd7) begin failures++; $display("FAIL gap_fill got=%0d exp=7", fill); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    cfg_len = 4'd1; cfg_pattern = {21'd0, 3'd7}; cfg_overlap = 1'b1;
    do_clear();
    for (int i = 0; i < 300; i++) begin
      send(3'd7);
      if (match === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 300) begin failures++; $display("FAIL b2b_pulses got=%0d exp=300", pulses); end
    checks++;
    if (match_count !== 8'd255) begin failures++; $display("FAIL b2b_saturate got=%0d exp=255", match_count); end
    checks++;
    if (fill !== 4'd8) begin failures++; $display("FAIL b2b_fill got=%0d exp=8", fill); end
    clear = 1'b1; in_valid = 1'b1; in_data = 3'd7;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (match_count !== 8'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", match_count); end
    checks++;
    if (fill !== 4'd0) begin failures++; $display("FAIL clear_fill got=%0d exp=0", fill); end
    checks++;
    if (match !== 1'b0) begin failures++; $display("FAIL clear_match got=%b exp=0", match); end
  endtask

  task automatic test_reset_mid();
    int a [4] = '{1, 5, 6, 0};
    int b [3] = '{6, 6, 3};
    int p [7] = '{1, 5, 6, 0, 6, 6, 3};
    cfg_len = 4'd7; set_pat7(); cfg_overlap = 1'b1;
    do_clear();
    for (int i = 0; i < 4; i++) send(3'(a[i]));
    checks++;
    if (fill !== 4'd4) begin failures++; $display("FAIL mid_prefill got=%0d exp=4", fill); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (fill !== 4'd0 || match !== 1'b0 || match_count !== 8'd0) begin
      failures++; $display("FAIL mid_async fill=%0d match=%b count=%0d exp 0/0/0", fill, match, match_count);
    end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(3'(b[i]));
      checks++;
      if (match !== 1'b0) begin failures++; $display("FAIL mid_stale i=%0d got=%b exp=0", i, match); end
    end
    for (int i = 0; i < 7; i++) begin
      send(3'(p[i]));
      checks++;
      if (match !== 1'(i == 6)) begin
        failures++; $display("FAIL mid_full i=%0d got=%b exp=%b", i, match, (i == 6));
      end
    end
    checks++;
    if (match_count !== 8'd1) begin failures++; $display("FAIL mid_count got=%0d exp=1", match_count); end
  endtask

  task automatic test_disabled();
    int p [7] = '{1, 5, 6, 0, 6, 6, 3};
    int lens [2] = '{0, 9};
    int hits;
    set_pat7(); cfg_overlap = 1'b1;
    for (int l = 0; l < 2; l++) begin
      cfg_len = 4'(lens[l]);
      do_clear();
      hits = 0;
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < 7; i++) begin
          send(3'(p[i]));
          if (match !== 1'b0) hits++;
        end
      end
      checks++;
      if (hits != 0) begin failures++; $display("FAIL disabled_match len=%0d got=%0d exp=0", lens[l], hits); end
      checks++;
      if (match_count !== 8'd0) begin failures++; $display("FAIL disabled_count len=%0d got=%0d exp=0", lens[l], match_count); end
      checks++;
      if (fill !== 4'd8) begin failures++; $display("FAIL disabled_fill len=%0d got=%0d exp=8", lens[l], fill); end
    end
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 3'd0;
    cfg_len = 4'd7; cfg_overlap = 1'b1; set_pat7();
    test_reset();
    test_basic();
    test_overlap();
    test_idle_gaps();
    test_back_to_back();
    test_reset_mid();
    test_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
